// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, pipeline-latch payload width and latch FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int WORD_W       = $bits(word_t);
  // Default stage payload is two words, e.g. instruction plus pc+4.
  localparam int LATCH_DATA_W = 2 * WORD_W;

  // Occupancy states of a pipeline latch; the encoding equals the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } latch_state_t;

endpackage

// File: rtl/pipe_skid_latch_if.sv
// Valid/ready handshake bundle between two pipeline stages, plus flush and occupancy.
interface pipe_skid_latch_if
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = LATCH_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              flush;
  logic [1:0]        count;

  // Environment side: drives the upstream payload and the downstream ready.
  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count
  );

  // Latch side.
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/pipe_reg_slice.sv
// One payload register with its valid bit; clear wins over load.
module pipe_reg_slice #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Entry register: clear empties and zeroes, load captures a new payload.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the payload is reset too, so a drained latch presents zeros rather than stale data.
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_skid_latch.sv
// Pipeline stage latch: two-entry skid buffer with registered in_ready (SKID=1)
// or single-entry latch with pass-through ready (SKID=0). Flush empties it.
module pipe_skid_latch
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = LATCH_DATA_W,
  parameter bit SKID   = 1'b1
) (
  input logic              CLK,
  input logic              nRST,
  pipe_skid_latch_if.slave bus
);

  latch_state_t      r_state;
  latch_state_t      w_next_state;
  logic              w_in_ready;
  logic              w_xfer_in;
  logic              w_xfer_out;
  logic              w_main_load;
  logic              w_main_clear;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_main_valid;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_main_din;
  logic [DATA_W-1:0] w_main_data;
  logic [DATA_W-1:0] w_skid_data;

  // A flush squashes the incoming payload; a consume coincident with flush still counts.
  assign w_xfer_in  = bus.in_valid && w_in_ready && !bus.flush;
  assign w_xfer_out = w_main_valid && bus.out_ready;

  // Occupancy state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= EMPTY;
    else       r_state <= w_next_state;
  end

  // Next occupancy from the in/out transfers; flush overrides everything.
  always_comb begin
    // NOTE: the default assignment up front covers every path, so no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      EMPTY: if (w_xfer_in) w_next_state = ONE;
      ONE: begin
        if (w_xfer_out && !w_xfer_in)            w_next_state = EMPTY;
        else if (SKID && w_xfer_in && !w_xfer_out) w_next_state = TWO;
      end
      TWO:     if (w_xfer_out) w_next_state = ONE;
      default: w_next_state = EMPTY;
    endcase
    if (bus.flush) w_next_state = EMPTY;
  end

  // Entry controls: where the incoming payload lands and which entries drain.
  always_comb begin
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    case (r_state)
      EMPTY: w_main_load = w_xfer_in;
      ONE: begin
        w_main_load  = w_xfer_in && w_xfer_out;
        w_main_clear = w_xfer_out && !w_xfer_in;
        w_skid_load  = w_xfer_in && !w_xfer_out;
      end
      TWO: begin
        w_main_load      = w_xfer_out;
        w_main_from_skid = w_xfer_out;
        w_skid_clear     = w_xfer_out;
      end
      default: begin
        w_main_clear = 1'b1;
        w_skid_clear = 1'b1;
      end
    endcase
    if (bus.flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end
  end

  assign w_main_din = w_main_from_skid ? w_skid_data : bus.in_data;

  pipe_reg_slice #(.DATA_W(DATA_W)) u_main (
    .clk     (CLK),
    .rst_n   (nRST),
    .i_clear (w_main_clear),
    .i_load  (w_main_load),
    .i_data  (w_main_din),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  generate
    if (SKID) begin : g_skid
      logic r_in_ready;

      pipe_reg_slice #(.DATA_W(DATA_W)) u_skid (
        .clk     (CLK),
        .rst_n   (nRST),
        .i_clear (w_skid_clear),
        .i_load  (w_skid_load),
        .i_data  (bus.in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
      );

      // Registered ready: low only while both entries are full, no path from out_ready.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_in_ready <= 1'b1;
        else       r_in_ready <= (w_next_state != TWO);
      end

      assign w_in_ready = r_in_ready;
    end else begin : g_no_skid
      logic w_unused_skid_ctl;

      assign w_skid_valid      = 1'b0;
      assign w_skid_data       = '0;
      assign w_unused_skid_ctl = w_skid_load ^ w_skid_clear;
      // Single entry: accept when empty or when the held payload leaves this cycle.
      assign w_in_ready        = bus.out_ready || !w_main_valid;
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_main_valid;
  assign bus.out_data  = w_main_valid ? w_main_data : '0;
  assign bus.count     = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Self-checking bench: directed scenarios on both latch modes, then random
// traffic compared against a queue model of a bounded FIFO with flush.
module tb_pipe_skid_latch;
  import cpu_types_pkg::*;

  localparam int DW = LATCH_DATA_W;
  typedef logic [DW+3:0] obs_t;

  logic CLK = 1'b0;
  logic nRST;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 CLK = ~CLK;

  pipe_skid_latch_if #(.DATA_W(DW)) if1 ();
  pipe_skid_latch_if #(.DATA_W(DW)) if0 ();

  pipe_skid_latch #(.DATA_W(DW), .SKID(1'b1)) dut1 (.CLK(CLK), .nRST(nRST), .bus(if1.slave));
  pipe_skid_latch #(.DATA_W(DW), .SKID(1'b0)) dut0 (.CLK(CLK), .nRST(nRST), .bus(if0.slave));

  function automatic obs_t pack(input logic v, input logic [1:0] c, input logic r,
                                input logic [DW-1:0] d);
    return {v, c, r, d};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("valid=%b count=%0d in_ready=%b data=%h",
                     o[DW+3], o[DW+2:DW+1], o[DW], o[DW-1:0]);
  endfunction

  function automatic obs_t obs1();
    return pack(if1.out_valid, if1.count, if1.in_ready, if1.out_data);
  endfunction

  function automatic obs_t obs0();
    return pack(if0.out_valid, if0.count, if0.in_ready, if0.out_data);
  endfunction

  task automatic drive1(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
    if1.in_valid = v; if1.in_data = d; if1.out_ready = ordy; if1.flush = fl;
  endtask

  task automatic drive0(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
    if0.in_valid = v; if0.in_data = d; if0.out_ready = ordy; if0.flush = fl;
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    obs_t want;
    nRST = 1'b0;
    drive1(1'b0, '0, 1'b1, 1'b0);
    drive0(1'b0, '0, 1'b1, 1'b0);
    #12;
    want = pack(1'b0, 2'd0, 1'b1, '0);
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL reset_skid1: got %s want %s", fmt(obs1()), fmt(want));
    end
    n_checks++;
    if (obs0() !== want) begin
      n_errors++; $display("FAIL reset_skid0: got %s want %s", fmt(obs0()), fmt(want));
    end
    @(negedge CLK);
    nRST = 1'b1;
    cycle();
  endtask

  task automatic test_basic_flow();
    obs_t want;
    drive1(1'b1, 64'h0000_1234_0000_0004, 1'b1, 1'b0);
    cycle();
    want = pack(1'b1, 2'd1, 1'b1, 64'h0000_1234_0000_0004);
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL basic_flow_load: got %s want %s", fmt(obs1()), fmt(want));
    end
    drive1(1'b0, '0, 1'b1, 1'b0);
    cycle();
    want = pack(1'b0, 2'd0, 1'b1, '0);
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL basic_flow_drain: got %s want %s", fmt(obs1()), fmt(want));
    end
  endtask

  task automatic test_skid_fill();
    obs_t want;
    drive1(1'b1, 64'hA, 1'b0, 1'b0);
    cycle();
    want = pack(1'b1, 2'd1, 1'b1, 64'hA);
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL skid_fill_one: got %s want %s", fmt(obs1()), fmt(want));
    end
    drive1(1'b1, 64'hB, 1'b0, 1'b0);
    cycle();
    want = pack(1'b1, 2'd2, 1'b0, 64'hA);
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL skid_fill_two: got %s want %s", fmt(obs1()), fmt(want));
    end
    // Full and stalled: both entries hold, the offered 0xF is refused.
    drive1(1'b1, 64'hF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (obs1() !== want) begin
        n_errors++; $display("FAIL skid_hold[%0d]: got %s want %s", i, fmt(obs1()), fmt(want));
      end
    end
    drive1(1'b0, '0, 1'b1, 1'b0);
    cycle();
    want = pack(1'b1, 2'd1, 1'b1, 64'hB);
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL skid_drain_b: got %s want %s", fmt(obs1()), fmt(want));
    end
    cycle();
    want = pack(1'b0, 2'd0, 1'b1, '0);
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL skid_drain_empty: got %s want %s", fmt(obs1()), fmt(want));
    end
  endtask

  task automatic test_flush();
    obs_t want;
    drive1(1'b1, 64'h1, 1'b0, 1'b0);
    cycle();
    drive1(1'b1, 64'h2, 1'b0, 1'b0);
    cycle();
    want = pack(1'b1, 2'd2, 1'b0, 64'h1);
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL flush_setup: got %s want %s", fmt(obs1()), fmt(want));
    end
    drive1(1'b1, 64'hC, 1'b1, 1'b1);
    cycle();
    want = pack(1'b0, 2'd0, 1'b1, '0);
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL flush_from_two: got %s want %s", fmt(obs1()), fmt(want));
    end
    drive1(1'b0, '0, 1'b1, 1'b0);
    cycle();
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL flush_no_ghost: got %s want %s", fmt(obs1()), fmt(want));
    end
    drive1(1'b1, 64'h3, 1'b1, 1'b0);
    cycle();
    drive1(1'b1, 64'h4, 1'b0, 1'b1);
    cycle();
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL flush_from_one: got %s want %s", fmt(obs1()), fmt(want));
    end
    drive1(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    obs_t want;
    drive1(1'b1, 64'h5, 1'b0, 1'b0);
    cycle();
    drive1(1'b1, 64'h6, 1'b0, 1'b0);
    cycle();
    want = pack(1'b1, 2'd2, 1'b0, 64'h5);
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL async_setup: got %s want %s", fmt(obs1()), fmt(want));
    end
    #2;
    nRST = 1'b0;
    #1;
    want = pack(1'b0, 2'd0, 1'b1, '0);
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL async_reset_now: got %s want %s", fmt(obs1()), fmt(want));
    end
    drive1(1'b1, 64'hE0, 1'b1, 1'b0);
    #2;
    nRST = 1'b1;
    cycle();
    want = pack(1'b1, 2'd1, 1'b1, 64'hE0);
    n_checks++;
    if (obs1() !== want) begin
      n_errors++; $display("FAIL first_after_reset: got %s want %s", fmt(obs1()), fmt(want));
    end
    drive1(1'b0, '0, 1'b1, 1'b0);
    cycle();
  endtask

  task automatic test_skid0();
    obs_t want;
    drive0(1'b1, 64'h5, 1'b0, 1'b0);
    cycle();
    want = pack(1'b1, 2'd1, 1'b0, 64'h5);
    n_checks++;
    if (obs0() !== want) begin
      n_errors++; $display("FAIL skid0_stall_ready: got %s want %s", fmt(obs0()), fmt(want));
    end
    drive0(1'b1, 64'hD, 1'b1, 1'b0);
    #1;
    want = pack(1'b1, 2'd1, 1'b1, 64'h5);
    n_checks++;
    if (obs0() !== want) begin
      n_errors++; $display("FAIL skid0_pass_ready: got %s want %s", fmt(obs0()), fmt(want));
    end
    cycle();
    want = pack(1'b1, 2'd1, 1'b1, 64'hD);
    n_checks++;
    if (obs0() !== want) begin
      n_errors++; $display("FAIL skid0_no_bubble: got %s want %s", fmt(obs0()), fmt(want));
    end
    drive0(1'b0, '0, 1'b1, 1'b0);
    cycle();
    want = pack(1'b0, 2'd0, 1'b1, '0);
    n_checks++;
    if (obs0() !== want) begin
      n_errors++; $display("FAIL skid0_drain: got %s want %s", fmt(obs0()), fmt(want));
    end
  endtask

  // Reference: a bounded FIFO (capacity 2 or 1) that a flush empties.
  task automatic test_random();
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];
    logic          iv, ordy, fl, rdy1, rdy0;
    logic [DW-1:0] d;
    obs_t          want;
    nRST = 1'b0;
    drive1(1'b0, '0, 1'b1, 1'b0);
    drive0(1'b0, '0, 1'b1, 1'b0);
    #2;
    nRST = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 19) == 0);
      d    = {$urandom, $urandom};
      drive1(iv, d, ordy, fl);
      drive0(iv, d, ordy, fl);
      #1;
      rdy1 = (q1.size() < 2);
      rdy0 = ordy || (q0.size() == 0);
      want = pack(q1.size() != 0, 2'(q1.size()), rdy1, (q1.size() != 0) ? q1[0] : '0);
      n_checks++;
      if (obs1() !== want) begin
        n_errors++; $display("FAIL random_skid1 cyc %0d: got %s want %s", i, fmt(obs1()), fmt(want));
      end
      want = pack(q0.size() != 0, 2'(q0.size()), rdy0, (q0.size() != 0) ? q0[0] : '0);
      n_checks++;
      if (obs0() !== want) begin
        n_errors++; $display("FAIL random_skid0 cyc %0d: got %s want %s", i, fmt(obs0()), fmt(want));
      end
      cycle();
      if (q1.size() != 0 && ordy) void'(q1.pop_front());
      if (fl) q1.delete();
      else if (iv && rdy1) q1.push_back(d);
      if (q0.size() != 0 && ordy) void'(q0.pop_front());
      if (fl) q0.delete();
      else if (iv && rdy0) q0.push_back(d);
    end
    drive1(1'b0, '0, 1'b1, 1'b0);
    drive0(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_flow();
    test_skid_fill();
    test_flush();
    test_async_reset();
    test_skid0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
